alu_acc_seq: RTL and testbench
==============================

# alu_acc_seq

Accumulator-based operand sequencer that sits directly upstream of the combinational `alu`. It accepts commands over a valid/ready handshake and drives the ALU's `A`, `B` and `Sel` inputs from registers. It captures `Rout` and `Overout` back into an accumulator and presents each result downstream over a second valid/ready handshake. A sticky overflow flag records any overflow since the last clear.

## Interface
- `Width`, default 3: operand/accumulator/result width; must equal the `Width` of the attached `alu`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_load`  in  1  1: load `cmd_operand` into the accumulator (no ALU op); 0: ALU op.
- `cmd_sel`  in  3  ALU operation select; passed through opaquely.
- `cmd_operand`  in  Width  B operand, or load value.
- `alu_a`  out  Width  to `alu.A`; registered accumulator snapshot.
- `alu_b`  out  Width  to `alu.B`; registered operand.
- `alu_sel`  out  3  to `alu.Sel`; registered.
- `alu_rout`  in  Width  from `alu.Rout`.
- `alu_overout`  in  1  from `alu.Overout`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts result.
- `res_data`  out  Width  result (new accumulator value).
- `res_over`  out  1  overflow for this result.
- `ovf_sticky`  out  1  OR of all `res_over` since reset or clear.
- `clr_sticky`  in  1  clears `ovf_sticky`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, with `cmd_load`=1: `acc`<=`cmd_operand`, `res_data`<=`cmd_operand`, `res_over`<=0, go to RESP.
  - On `cmd_valid`, with `cmd_load`=0: `alu_a`<=`acc`, `alu_b`<=`cmd_operand`, `alu_sel`<=`cmd_sel`, go to EXEC.
- **EXEC**
  - One settle cycle for the combinational ALU.
  - At the end of EXEC: `acc`<=`alu_rout`, `res_data`<=`alu_rout`, `res_over`<=`alu_overout`, and `ovf_sticky` is set if `alu_overout`=1. Go to RESP.
- **RESP**
  - `res_valid`=1; `res_data` and `res_over` are held stable.
  - On `res_ready`=1: go to IDLE.
- Outputs only valid in their own state:
  - `cmd_ready` is combinational: (state==IDLE) && !`rst`.
  - `res_valid` is combinational: (state==RESP).
- `alu_a`, `alu_b` and `alu_sel` hold their last values between commands. A load command does not change them.
- Arithmetic: no width change anywhere. `alu_rout` is stored as-is. Wrap-around and overflow are purely the ALU's; this block never computes or saturates.
- `ovf_sticky` rules:
  - Set has priority over `clr_sticky` in the same cycle.
  - `clr_sticky` otherwise clears it at the next edge, in any state.

## Timing
- Reset (edge with `rst`=1): state=IDLE; `acc`, `alu_a`, `alu_b`, `alu_sel`, `res_data`, `res_over` and `ovf_sticky` all become 0. `res_valid`=0, and `cmd_ready`=0 while `rst` is high.
- Reset mid-operation (in EXEC or RESP): any in-flight command and any unread result are discarded. The state is IDLE on the next cycle.
- ALU op, accepted at edge k:
  - `alu_*` valid after k.
  - Result captured at k+1.
  - `res_valid`=1 during cycle k+1..k+2.
  - Minimum 3 cycles per op with `res_ready` held high.
- Load, accepted at edge k: `res_valid`=1 after k. Minimum 2 cycles per load.
- Backpressure: RESP is held indefinitely while `res_ready`=0. `cmd_ready` stays 0; `cmd_valid` may stay asserted but is not consumed.
- Handshakes: a transfer occurs only on an edge where both valid and ready are 1. `cmd_*` inputs are sampled only on that edge.
- No combinational path from `alu_rout`/`alu_overout` to any output.

## Test plan
All directed tests use `Width`=3 and a bench ALU stub: `Sel`=0 gives Rout=(A+B) mod 8 and Overout=carry.
- **Reset:** assert `rst` for 2 cycles, then release → `res_valid`=0, `ovf_sticky`=0, `alu_a`/`alu_b`/`alu_sel`=0, and `cmd_ready`=1 in the first cycle after release.
- **Load then add:**
  - Load 5 → `res_data`=5, `res_over`=0 one cycle after accept.
  - Then `sel`=0, operand 2 → `alu_a`=5, `alu_b`=2, `alu_sel`=0; `res_data`=7, `res_over`=0 two cycles after accept.
- **Overflow:**
  - With `acc`=7, add 3 → `res_data`=2, `res_over`=1, `ovf_sticky`=1.
  - Pulse `clr_sticky` → 0 next cycle.
  - Repeat, with `clr_sticky` high in the capture cycle → `ovf_sticky` stays 1.
- **Backpressure:** hold `res_ready`=0 for 5 cycles in RESP with `cmd_valid`=1 → `res_valid`, `res_data` and `res_over` stable, `cmd_ready`=0, and no new command accepted until after the `res_ready` edge.
- **Reset mid-op:** assert `rst` during EXEC → next cycle IDLE, `acc`=0, `res_valid`=0, `ovf_sticky`=0. The pending result is never presented.
- **Select sweep:** issue `sel`=0..7 with operand 6 → `alu_sel` equals each `cmd_sel` exactly, and `res_data` tracks the stub `alu_rout` each time.

Source files
------------

// File: rtl/alu_acc_seq.sv
// Accumulator operand sequencer feeding a combinational ALU and capturing its result.
// Latency: ALU op result valid 2 edges after accept, load result 1 edge after accept.
// Backpressure: RESP holds result until res_ready; no command accepted meanwhile.
module alu_acc_seq #(
    parameter int Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_sel,
    input  logic [Width-1:0] cmd_operand,
    output logic [Width-1:0] alu_a,
    output logic [Width-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [Width-1:0] alu_rout,
    input  logic             alu_overout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Width-1:0] res_data,
    output logic             res_over,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [Width-1:0] acc_q, acc_d;
    logic [Width-1:0] alu_a_q, alu_a_d;
    logic [Width-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [Width-1:0] res_data_q, res_data_d;
    logic             res_over_q, res_over_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        res_data_d   = res_data_q;
        res_over_d   = res_over_q;
        ovf_sticky_d = ovf_sticky_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d      = cmd_operand;
                        res_data_d = cmd_operand;
                        res_over_d = 1'b0;
                        state_d    = RESP;
                    end else begin
                        alu_a_d   = acc_q;
                        alu_b_d   = cmd_operand;
                        alu_sel_d = cmd_sel;
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                acc_d      = alu_rout;
                res_data_d = alu_rout;
                res_over_d = alu_overout;
                state_d    = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture-cycle overflow wins over a simultaneous clear.
        if ((state_q == EXEC) && alu_overout) begin
            ovf_sticky_d = 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            res_data_q   <= '0;
            res_over_q   <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            res_data_q   <= res_data_d;
            res_over_q   <= res_over_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign res_valid  = (state_q == RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign res_data   = res_data_q;
    assign res_over   = res_over_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq with a small ALU stub (Width=3).
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_alu_acc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_sel;
    logic [2:0] cmd_operand;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [2:0] alu_sel;
    logic [2:0] alu_rout;
    logic       alu_overout;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_data;
    logic       res_over;
    logic       ovf_sticky;
    logic       clr_sticky;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [2:0] EXP_A [8] = '{3'd3, 3'd1, 3'd3, 3'd2, 3'd6, 3'd0, 3'd7, 3'd7};
    localparam logic [2:0] EXP_R [8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd0, 3'd7, 3'd7, 3'd6};
    localparam logic       EXP_O [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    alu_acc_seq #(.Width(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_load    (cmd_load),
        .cmd_sel     (cmd_sel),
        .cmd_operand (cmd_operand),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_rout    (alu_rout),
        .alu_overout (alu_overout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_over    (res_over),
        .ovf_sticky  (ovf_sticky),
        .clr_sticky  (clr_sticky)
    );

    // ALU stub: sel 0 is add with carry-out; other selects give distinct patterns.
    logic [3:0] sum;
    always_comb begin
        sum         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overout = 1'b0;
        case (alu_sel)
            3'd0: begin alu_rout = sum[2:0]; alu_overout = sum[3]; end
            3'd1: alu_rout = alu_a - alu_b;
            3'd2: alu_rout = alu_a & alu_b;
            3'd3: alu_rout = alu_a | alu_b;
            3'd4: alu_rout = alu_a ^ alu_b;
            3'd5: alu_rout = ~alu_a;
            3'd6: alu_rout = alu_a;
            default: alu_rout = alu_b;
        endcase
    end

    // Starts on a falling edge in IDLE, ends on a falling edge in RESP.
    task automatic issue(input logic ld, input logic [2:0] sel, input logic [2:0] op);
        cmd_valid   = 1'b1;
        cmd_load    = ld;
        cmd_sel     = sel;
        cmd_operand = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!ld) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready_hi got %b want 0", cmd_ready); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); else n_pass++;
        n_chk++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b want 0", res_valid); else n_pass++;
        n_chk++; if (ovf_sticky !== 1'b0) $display("FAIL rst_sticky got %b want 0", ovf_sticky); else n_pass++;
        n_chk++; if ({alu_a, alu_b, alu_sel} !== 9'd0)
            $display("FAIL rst_alu_regs got %h/%h/%h want 0/0/0", alu_a, alu_b, alu_sel); else n_pass++;
    endtask

    task automatic test_load_add();
        issue(1'b1, 3'd0, 3'd5);
        n_chk++; if (res_valid !== 1'b1 || res_data !== 3'd5 || res_over !== 1'b0)
            $display("FAIL load5 got v=%b d=%0d o=%b want v=1 d=5 o=0", res_valid, res_data, res_over); else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = 3'd0; cmd_operand = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if (alu_a !== 3'd5 || alu_b !== 3'd2 || alu_sel !== 3'd0)
            $display("FAIL add_operands got a=%0d b=%0d s=%0d want a=5 b=2 s=0", alu_a, alu_b, alu_sel); else n_pass++;
        n_chk++; if (res_valid !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL add_exec_hs got v=%b r=%b want v=0 r=0", res_valid, cmd_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b1 || res_data !== 3'd7 || res_over !== 1'b0)
            $display("FAIL add_result got v=%b d=%0d o=%b want v=1 d=7 o=0", res_valid, res_data, res_over); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        issue(1'b1, 3'd0, 3'd7);
        @(negedge clk);
        issue(1'b0, 3'd0, 3'd3);
        n_chk++; if (res_data !== 3'd2 || res_over !== 1'b1 || ovf_sticky !== 1'b1)
            $display("FAIL ovf_add got d=%0d o=%b s=%b want d=2 o=1 s=1", res_data, res_over, ovf_sticky); else n_pass++;
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        n_chk++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf_sticky); else n_pass++;
        issue(1'b1, 3'd0, 3'd7);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = 3'd0; cmd_operand = 3'd3;
        @(negedge clk);
        cmd_valid  = 1'b0;
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        n_chk++; if (ovf_sticky !== 1'b1 || res_over !== 1'b1)
            $display("FAIL ovf_set_priority got s=%b o=%b want s=1 o=1", ovf_sticky, res_over); else n_pass++;
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        n_chk++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_clear_idle got %b want 0", ovf_sticky); else n_pass++;
    endtask

    task automatic test_backpressure();
        issue(1'b1, 3'd0, 3'd4);
        @(negedge clk);
        res_ready = 1'b0;
        issue(1'b0, 3'd0, 3'd1);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 3'd6;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (res_valid !== 1'b1 || res_data !== 3'd5 || res_over !== 1'b0 || cmd_ready !== 1'b0)
                $display("FAIL bp_hold[%0d] got v=%b d=%0d o=%b r=%b want v=1 d=5 o=0 r=0",
                         i, res_valid, res_data, res_over, cmd_ready); else n_pass++;
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL bp_release got v=%b r=%b want v=0 r=1", res_valid, cmd_ready); else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if (res_valid !== 1'b1 || res_data !== 3'd6)
            $display("FAIL bp_next_cmd got v=%b d=%0d want v=1 d=6", res_valid, res_data); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic seen_valid;
        issue(1'b1, 3'd0, 3'd7);
        @(negedge clk);
        issue(1'b0, 3'd0, 3'd3);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = 3'd0; cmd_operand = 3'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b0 || cmd_ready !== 1'b0 || ovf_sticky !== 1'b0 || res_data !== 3'd0)
            $display("FAIL rmid_state got v=%b r=%b s=%b d=%0d want v=0 r=0 s=0 d=0",
                     res_valid, cmd_ready, ovf_sticky, res_data); else n_pass++;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (res_valid !== 1'b0) seen_valid = 1'b1;
            @(negedge clk);
        end
        n_chk++; if (seen_valid !== 1'b0) $display("FAIL rmid_no_result got %b want 0", seen_valid); else n_pass++;
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = 3'd0; cmd_operand = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if (alu_a !== 3'd0) $display("FAIL rmid_acc got %0d want 0", alu_a); else n_pass++;
        @(negedge clk);
        n_chk++; if (res_data !== 3'd4) $display("FAIL rmid_result got %0d want 4", res_data); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_sel_sweep();
        issue(1'b1, 3'd0, 3'd3);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = 3'(i); cmd_operand = 3'd6;
            @(negedge clk);
            cmd_valid = 1'b0;
            n_chk++; if (alu_sel !== 3'(i) || alu_a !== EXP_A[i] || alu_b !== 3'd6)
                $display("FAIL sweep_op[%0d] got s=%0d a=%0d b=%0d want s=%0d a=%0d b=6",
                         i, alu_sel, alu_a, alu_b, i, EXP_A[i]); else n_pass++;
            @(negedge clk);
            n_chk++; if (res_data !== EXP_R[i] || res_over !== EXP_O[i])
                $display("FAIL sweep_res[%0d] got d=%0d o=%b want d=%0d o=%b",
                         i, res_data, res_over, EXP_R[i], EXP_O[i]); else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_load    = 1'b0;
        cmd_sel     = 3'd0;
        cmd_operand = 3'd0;
        res_ready   = 1'b1;
        clr_sticky  = 1'b0;
        test_reset();
        test_load_add();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_sel_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
